cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_pkg.sv | 19 +
 rtl/rr_arb2.sv | 22 ++
 rtl/cache_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the I/D cache bus arbiter and the caches it serves.
package cache_pkg;

   localparam int LINE_WORDS_DEF = 16;
   localparam int OFFS_DEF       = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester that was not served last wins.
module rr_arb2
   import cache_pkg::*;
(
   input  logic [1:0] req,        // [0] Icache, [1] Dcache
   input  owner_e     last,
   output logic       gnt_valid,
   output owner_e     gnt
);

   always_comb begin
      gnt_valid = |req;
      gnt       = OWN_I;
      case (req)
         2'b01:   gnt = OWN_I;
         2'b10:   gnt = OWN_D;
         2'b11:   gnt = (last == OWN_I) ? OWN_D : OWN_I;
         default: gnt = OWN_I;
      endcase
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one SRAM-like bus between Icache refills and Dcache refills/write-backs,
// moving a whole line per grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; pick a requester via rr_arb2 and latch its request
// ST_ADDR | sen=1 with the aligned line address until addr_ok
// ST_DATA | one beat per data_ok, cnt indexes the word in the line
// ST_DONE | single-cycle done pulse to the owner
module cache_bus_arbiter
   import cache_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int OFFS       = OFFS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_rvalid,
   output logic [3:0]  i_idx,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_rvalid,
   output logic [3:0]  d_idx,
   output logic        d_done,
   output logic [31:0] rdata,
   output logic        sen,
   output logic        wen,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] s_rdata
);

   localparam logic [3:0]  CNT_LAST  = 4'(LINE_WORDS - 1);
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFS) - 32'd1);

   arb_state_e  state_q, state_d;
   owner_e      owner_q, owner_d;
   owner_e      last_q, last_d;
   logic        we_r_q, we_r_d;
   logic [31:0] addr_r_q, addr_r_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        gnt_valid;
   owner_e      gnt;

   rr_arb2 u_rr_arb2 (
      .req       ({d_req, i_req}),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_I;
         last_q   <= OWN_I;
         we_r_q   <= 1'b0;
         addr_r_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         we_r_q   <= we_r_d;
         addr_r_q <= addr_r_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      we_r_d   = we_r_q;
      addr_r_d = addr_r_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               owner_d  = gnt;
               we_r_d   = (gnt == OWN_D) ? d_we : 1'b0;
               addr_r_d = ((gnt == OWN_D) ? d_addr : i_addr) & ADDR_MASK;
               cnt_d    = '0;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // last moves only once the bus has committed to this owner
            if (addr_ok) begin
               last_d  = owner_q;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (data_ok) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   logic in_data, in_addr, in_done, own_d, beat_rd;

   always_comb begin
      in_data  = (state_q == ST_DATA);
      in_addr  = (state_q == ST_ADDR);
      in_done  = (state_q == ST_DONE);
      own_d    = (owner_q == OWN_D);
      beat_rd  = in_data & data_ok & ~we_r_q;

      i_rvalid = beat_rd & ~own_d;
      d_rvalid = beat_rd & own_d;
      i_idx    = (in_data & ~own_d) ? cnt_q : 4'd0;
      d_idx    = (in_data & own_d) ? cnt_q : 4'd0;
      i_done   = in_done & ~own_d;
      d_done   = in_done & own_d;

      sen      = in_addr;
      wen      = in_addr & we_r_q;
      s_addr   = in_addr ? addr_r_q : 32'd0;
      s_wdata  = (in_data & we_r_q) ? d_wdata : 32'd0;
      // gated so the read-data path is also quiet while reset is held
      rdata    = rst ? s_rdata : 32'd0;
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter with a cycle-level SRAM-bus responder.
module tb_cache_bus_arbiter;
   import cache_pkg::*;

   localparam int LW = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic        i_rvalid, i_done, d_rvalid, d_done;
   logic [3:0]  i_idx, d_idx;
   logic [31:0] rdata, s_addr, s_wdata, s_rdata;
   logic        sen, wen, addr_ok, data_ok;

   always #5 clk = ~clk;

   cache_bus_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rvalid (i_rvalid),
      .i_idx    (i_idx),
      .i_done   (i_done),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rvalid (d_rvalid),
      .d_idx    (d_idx),
      .d_done   (d_done),
      .rdata    (rdata),
      .sen      (sen),
      .wen      (wen),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .addr_ok  (addr_ok),
      .data_ok  (data_ok),
      .s_rdata  (s_rdata)
   );

   // Dcache write-back source: word follows the index the arbiter presents
   assign d_wdata = 32'h0000_00A0 + {28'd0, d_idx};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        own_d;
      logic        we;
      logic [3:0]  idx;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
   } grant_t;

   beat_t  beat_q[$];
   grant_t grant_q[$];
   logic   done_q[$];

   task automatic push_txn(input logic own_d, input logic we, input logic [31:0] addr,
                           input int nbeats, input bit with_done);
      grant_t g;
      beat_t  b;
      g.we   = we;
      g.addr = addr & 32'hFFFF_FFC0;
      grant_q.push_back(g);
      for (int k = 0; k < nbeats; k++) begin
         b.own_d = own_d;
         b.we    = we;
         b.idx   = 4'(k);
         b.data  = we ? (32'h0000_00A0 + 32'(k)) : 32'(k);
         beat_q.push_back(b);
      end
      if (with_done) done_q.push_back(own_d);
   endtask

   // bus responder: decides addr_ok/data_ok for the current cycle just after each edge
   int addr_dly  = 0;
   int gap       = 0;
   bit early_dok = 1'b0;
   int cur_phase = 0;
   int nxt_phase = 0;
   int sen_cyc   = 0;
   int resp_beat = 0;
   bit gap_tog   = 1'b0;

   initial begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      s_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         addr_ok   = 1'b0;
         data_ok   = 1'b0;
         s_rdata   = 32'hDEAD_BEEF;
         cur_phase = nxt_phase;
         if (!rst) begin
            cur_phase = 0;
            nxt_phase = 0;
            sen_cyc   = 0;
            resp_beat = 0;
         end else if (cur_phase == 2) begin
            if (gap == 0 || gap_tog) begin
               data_ok = 1'b1;
               s_rdata = 32'(resp_beat);
               resp_beat++;
               if (resp_beat == LW) begin
                  resp_beat = 0;
                  nxt_phase = 0;
               end
            end
            gap_tog = !gap_tog;
         end else if (sen) begin
            if (sen_cyc == addr_dly) begin
               addr_ok   = 1'b1;
               nxt_phase = 2;
               sen_cyc   = 0;
               gap_tog   = 1'b0;
            end else begin
               if (early_dok && sen_cyc == 0) data_ok = 1'b1;
               sen_cyc++;
            end
         end
      end
   end

   // monitor: samples on the falling edge and pops the scoreboard
   bit prev_sen      = 1'b0;
   int sen_len       = 0;
   int cyc           = 0;
   int last_beat_cyc = -100;

   initial begin
      grant_t g;
      beat_t  b;
      logic   o;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            prev_sen = 1'b0;
            sen_len  = 0;
         end else begin
            if (sen && !prev_sen) begin
               if (grant_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
               else begin
                  g = grant_q.pop_front();
                  chk("s_addr", s_addr, g.addr);
                  chk("wen", {31'd0, wen}, {31'd0, g.we});
               end
            end
            if (sen) sen_len++;
            if (!sen && prev_sen) begin
               chk("sen_len", 32'(sen_len), 32'(addr_dly + 1));
               sen_len = 0;
            end
            prev_sen = sen;

            if (data_ok && cur_phase == 2) begin
               if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
               else begin
                  b = beat_q.pop_front();
                  chk("beat_idx", {28'd0, (b.own_d ? d_idx : i_idx)}, {28'd0, b.idx});
                  chk("other_idx", {28'd0, (b.own_d ? i_idx : d_idx)}, 32'd0);
                  chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, (!b.we && !b.own_d)});
                  chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, (!b.we && b.own_d)});
                  if (b.we) chk("s_wdata", s_wdata, b.data);
                  else      chk("rdata", rdata, b.data);
                  last_beat_cyc = cyc;
               end
            end else begin
               chk("rvalid_offbeat", {30'd0, i_rvalid, d_rvalid}, 32'd0);
               if (cur_phase == 2 && beat_q.size() > 0)
                  chk("idx_hold", {28'd0, (beat_q[0].own_d ? d_idx : i_idx)},
                      {28'd0, beat_q[0].idx});
               if (cur_phase != 2) begin
                  chk("idle_wdata", s_wdata, 32'd0);
                  chk("idle_idx", {24'd0, i_idx, d_idx}, 32'd0);
               end
            end

            if (i_done || d_done) begin
               chk("done_onehot", {31'd0, i_done & d_done}, 32'd0);
               if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
               else begin
                  o = done_q.pop_front();
                  chk("done_owner", {31'd0, d_done}, {31'd0, o});
                  chk("done_after_last_beat", 32'(cyc - last_beat_cyc), 32'd1);
               end
            end
         end
      end
   end

   int drop_i_at = -1;

   task automatic run_reqs(input bit hold, input int n_done, input int budget, output int took);
      int seen = 0;
      int t    = 0;
      while (seen < n_done && t < budget) begin
         @(negedge clk);
         t++;
         if (drop_i_at >= 0 && i_rvalid && i_idx == 4'(drop_i_at)) i_req = 1'b0;
         if (i_done || d_done) begin
            seen++;
            if (!hold) begin
               if (i_done) i_req = 1'b0;
               if (d_done) d_req = 1'b0;
            end
         end
      end
      if (seen < n_done) chk("done_timeout", 32'(seen), 32'(n_done));
      if (hold) begin
         i_req = 1'b0;
         d_req = 1'b0;
      end
      took = t;
   endtask

   initial begin
      int took;
      int t;
      rst    = 1'b0;
      i_req  = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      i_addr = 32'd0;
      d_addr = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {18'd0, sen, wen, i_rvalid, d_rvalid, i_done, d_done, i_idx, d_idx}, 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_s_wdata", s_wdata, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // contention right after reset: D, then I, D, I while both stay asserted
      i_addr = 32'h1FC0_0048;
      d_addr = 32'h8000_1000;
      d_we   = 1'b0;
      push_txn(1'b1, 1'b0, d_addr, LW, 1'b1);
      push_txn(1'b0, 1'b0, i_addr, LW, 1'b1);
      push_txn(1'b1, 1'b0, d_addr, LW, 1'b1);
      push_txn(1'b0, 1'b0, i_addr, LW, 1'b1);
      i_req = 1'b1;
      d_req = 1'b1;
      run_reqs(1'b1, 4, 200, took);
      repeat (3) @(negedge clk);

      // single Icache refill: req-cycle through done-cycle spans LW+3 cycles
      push_txn(1'b0, 1'b0, 32'h1FC0_0048, LW, 1'b1);
      i_req = 1'b1;
      run_reqs(1'b0, 1, 60, took);
      chk("latency", 32'(took), 32'(LW + 2));
      repeat (2) @(negedge clk);

      // Dcache write-back
      d_we   = 1'b1;
      d_addr = 32'h8000_1000;
      push_txn(1'b1, 1'b1, d_addr, LW, 1'b1);
      d_req = 1'b1;
      run_reqs(1'b0, 1, 60, took);
      repeat (2) @(negedge clk);

      // slow bus: delayed addr_ok, gapped beats, stray data_ok during ADDR
      addr_dly  = 5;
      gap       = 1;
      early_dok = 1'b1;
      d_we      = 1'b1;
      d_addr    = 32'h0001_237F;
      push_txn(1'b1, 1'b1, d_addr, LW, 1'b1);
      d_req = 1'b1;
      run_reqs(1'b0, 1, 120, took);
      repeat (2) @(negedge clk);
      i_addr = 32'h0000_0FFC;
      push_txn(1'b0, 1'b0, i_addr, LW, 1'b1);
      i_req = 1'b1;
      run_reqs(1'b0, 1, 120, took);
      addr_dly  = 0;
      gap       = 0;
      early_dok = 1'b0;
      repeat (2) @(negedge clk);

      // Icache drops its request mid-line; line still completes, no regrant
      i_addr    = 32'h1FC0_0048;
      drop_i_at = 3;
      push_txn(1'b0, 1'b0, i_addr, LW, 1'b1);
      i_req = 1'b1;
      run_reqs(1'b0, 1, 60, took);
      drop_i_at = -1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("no_regrant", {31'd0, sen}, 32'd0);
      end

      // reset in the middle of a Dcache refill
      d_we   = 1'b0;
      d_addr = 32'h8000_1000;
      push_txn(1'b1, 1'b0, d_addr, 7, 1'b0);
      d_req = 1'b1;
      t = 0;
      while (!(d_rvalid && d_idx == 4'd6) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("beat6_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_ctrl", {18'd0, sen, wen, i_rvalid, d_rvalid, i_done, d_done, i_idx, d_idx}, 32'd0);
      chk("abort_s_addr", s_addr, 32'd0);
      chk("abort_s_wdata", s_wdata, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      d_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_txn(1'b0, 1'b0, i_addr, LW, 1'b1);
      i_req = 1'b1;
      run_reqs(1'b0, 1, 60, took);
      chk("latency_after_reset", 32'(took), 32'(LW + 2));
      repeat (4) @(negedge clk);

      chk("grant_q_left", 32'(grant_q.size()), 32'd0);
      chk("beat_q_left", 32'(beat_q.size()), 32'd0);
      chk("done_q_left", 32'(done_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
